// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the op encodings, the FSM state encodings and small op-decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SIGN = 2'b10
    } state_e;

    // Signed ops work on operand magnitudes and fix the sign afterwards.
    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_negc.sv
// Conditional two's-complement negate.
// Ports: neg - negate when high; x - input value; y_c - x or -x (combinational).
module muldiv_negc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y_c
);

    assign y_c = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per
// cycle for WIDTH cycles, then one sign-fix cycle before results land.
// Divide support is built only when MULDIV_DIV_EN is defined; otherwise a
// divide request just pulses done and leaves HI/LO untouched.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset
//   start, op, a, b  - request, opcode (MULTU/MULT/DIVU/DIV), operands
//   hi_we, lo_we, wd - direct HI/LO writes, honoured only when idle
//   busy, done       - operation in flight / one-cycle completion pulse
//   hi, lo           - result registers
//   divzero          - last divide had a zero divisor
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d;     // product high half / partial remainder
    logic [WIDTH-1:0]   p_lo_q, p_lo_d;     // multiplier shift-out / quotient shift-in
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               sgn_a_q, sgn_a_d;
    logic               sgn_b_q, sgn_b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;

    logic               neg_a_c, neg_b_c, accept_c;
    logic [WIDTH-1:0]   mag_a_c, mag_b_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [2*WIDTH-1:0] mul_next_c, prod_fix_c;

    // Operand magnitudes; sign flags are already gated by the signed-op decode.
    assign neg_a_c = op_is_signed(op_e'(op)) && a[WIDTH-1];
    assign neg_b_c = op_is_signed(op_e'(op)) && b[WIDTH-1];

    muldiv_negc #(.WIDTH(WIDTH)) u_neg_a (.neg(neg_a_c), .x(a), .y_c(mag_a_c));
    muldiv_negc #(.WIDTH(WIDTH)) u_neg_b (.neg(neg_b_c), .x(b), .y_c(mag_b_c));

    // Shift-add step: add multiplicand when the outgoing multiplier bit is set.
    assign mul_sum_c  = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mag_b_q} : '0);
    assign mul_next_c = {mul_sum_c, p_lo_q[WIDTH-1:1]};

    muldiv_negc #(.WIDTH(2*WIDTH)) u_neg_p (
        .neg (sgn_a_q ^ sgn_b_q),
        .x   ({p_hi_q, p_lo_q}),
        .y_c (prod_fix_c)
    );

`ifdef MULDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH:0]     div_shift_c, div_diff_c;
    logic [2*WIDTH-1:0] div_next_c;
    logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;

    assign accept_c = (state_q == ST_IDLE) && start;

    // Restoring step: keep the trial difference unless it borrowed.
    assign div_shift_c = {p_hi_q, p_lo_q[WIDTH-1]};
    assign div_diff_c  = div_shift_c - {1'b0, mag_b_q};
    assign div_next_c  = div_diff_c[WIDTH]
                       ? {div_shift_c[WIDTH-1:0], p_lo_q[WIDTH-2:0], 1'b0}
                       : {div_diff_c[WIDTH-1:0],  p_lo_q[WIDTH-2:0], 1'b1};

    // Quotient takes the XOR of signs, remainder follows the dividend.
    muldiv_negc #(.WIDTH(WIDTH)) u_neg_q (.neg(sgn_a_q ^ sgn_b_q), .x(p_lo_q), .y_c(quo_fix_c));
    muldiv_negc #(.WIDTH(WIDTH)) u_neg_r (.neg(sgn_a_q),           .x(p_hi_q), .y_c(rem_fix_c));
`else
    assign accept_c = (state_q == ST_IDLE) && start && !op_is_div(op_e'(op));
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        mag_b_d   = mag_b_q;
        sgn_a_d   = sgn_a_q;
        sgn_b_d   = sgn_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        bzero_d   = bzero_q;
        a_d       = a_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
`ifndef MULDIV_DIV_EN
                // Divide requested without a divider: acknowledge only.
                if (start && op_is_div(op_e'(op))) done_d = 1'b1;
`endif
                if (accept_c) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    p_hi_d    = '0;
                    p_lo_d    = mag_a_c;
                    mag_b_d   = mag_b_c;
                    sgn_a_d   = neg_a_c;
                    sgn_b_d   = neg_b_c;
                    divzero_d = 1'b0;
`ifdef MULDIV_DIV_EN
                    is_div_d  = op_is_div(op_e'(op));
                    bzero_d   = (b == '0);
                    a_d       = a;
`endif
                end
            end

            ST_RUN: begin
`ifdef MULDIV_DIV_EN
                if (is_div_q) {p_hi_d, p_lo_d} = div_next_c;
                else          {p_hi_d, p_lo_d} = mul_next_c;
`else
                {p_hi_d, p_lo_d} = mul_next_c;
`endif
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = ST_SIGN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_SIGN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix_c;
                end else if (bzero_q) begin
                    lo_d      = '1;
                    hi_d      = a_q;
                    divzero_d = 1'b1;
                end else begin
                    lo_d = quo_fix_c;
                    hi_d = rem_fix_c;
                end
`else
                {hi_d, lo_d} = prod_fix_c;
`endif
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            mag_b_q   <= '0;
            sgn_a_q   <= 1'b0;
            sgn_b_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            mag_b_q   <= mag_b_d;
            sgn_a_q   <= sgn_a_d;
            sgn_b_q   <= sgn_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

`ifdef MULDIV_DIV_EN
    // Divide-only operand state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div_q <= 1'b0;
            bzero_q  <= 1'b0;
            a_q      <= '0;
        end else begin
            is_div_q <= is_div_d;
            bzero_q  <= bzero_d;
            a_q      <= a_d;
        end
    end
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign divzero = divzero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) against an arithmetic model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wd, hi, lo;
    logic         busy, done, divzero;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_hi, exp_lo;
    logic         exp_dz;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wd      (wd),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .divzero (divzero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of an op, from plain 64-bit arithmetic.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, y,
                                  inout logic [W-1:0] h, l, inout logic z);
        longint      sx, sy, q, r;
        logic [63:0] pu;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            2'b00: begin pu = 64'(x) * 64'(y); {h, l} = pu; z = 1'b0; end
            2'b01: begin q = sx * sy; {h, l} = 64'(q); z = 1'b0; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (y == '0) begin
                    l = '1; h = x; z = 1'b1;
                end else if (o == 2'b10) begin
                    l = x / y; h = x % y; z = 1'b0;
                end else begin
                    q = sx / sy; r = sx % sy;
                    l = 32'(q); h = 32'(r); z = 1'b0;
                end
`endif
            end
        endcase
    endfunction

    // Issue one op (with optional simultaneous HI/LO write), scramble inputs
    // while busy, and return in the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, y,
                         input logic wh, wl, input logic [W-1:0] wv);
        logic [W-1:0] rh, rl;
        logic         rz;
        start = 1'b1; op = o; a = x; b = y; hi_we = wh; lo_we = wl; wd = wv;
        if (wh) exp_hi = wv;
        if (wl) exp_lo = wv;
        rh = exp_hi; rl = exp_lo; rz = exp_dz;
        model(o, x, y, rh, rl, rz);
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
`ifndef MULDIV_DIV_EN
        if (o[1]) begin
            total++;
            if ({busy, done, hi, lo, divzero} !== {1'b0, 1'b1, exp_hi, exp_lo, exp_dz}) begin
                bad++;
                $display("FAIL nodiv_ack: got busy=%b done=%b hi=%h lo=%h dz=%b, expected busy=0 done=1 hi=%h lo=%h dz=%b",
                         busy, done, hi, lo, divzero, exp_hi, exp_lo, exp_dz);
            end
            return;
        end
`endif
        total++;
        if (hi !== exp_hi || lo !== exp_lo || divzero !== 1'b0) begin
            bad++;
            $display("FAIL accept: got hi=%h lo=%h dz=%b, expected hi=%h lo=%h dz=0",
                     hi, lo, divzero, exp_hi, exp_lo);
        end
        for (int c = 1; c <= W + 1; c++) begin
            total++;
            if ({busy, done} !== 2'b10) begin
                bad++;
                $display("FAIL busy_cycle %0d: got busy=%b done=%b, expected busy=1 done=0", c, busy, done);
            end
            start = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom;
            hi_we = 1'($urandom); lo_we = 1'($urandom); wd = $urandom;
            tick();
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        exp_hi = rh; exp_lo = rl; exp_dz = rz;
        total++;
        if ({busy, done, hi, lo, divzero} !== {1'b0, 1'b1, exp_hi, exp_lo, exp_dz}) begin
            bad++;
            $display("FAIL result op=%0d a=%h b=%h: got busy=%b done=%b hi=%h lo=%h dz=%b, expected busy=0 done=1 hi=%h lo=%h dz=%b",
                     o, x, y, busy, done, hi, lo, divzero, exp_hi, exp_lo, exp_dz);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wd = '0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        repeat (2) tick();
        total++;
        if ({busy, done, hi, lo, divzero} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h dz=%b, expected all zero",
                     busy, done, hi, lo, divzero);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_multu_latency();
        do_op(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, '0);
        total++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            bad++;
            $display("FAIL multu_const: got hi=%h lo=%h, expected hi=00000001 lo=fffffffe", hi, lo);
        end
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL done_width: got busy=%b done=%b, expected busy=0 done=0", busy, done);
        end
    endtask

    // Directed values; consecutive calls also exercise back-to-back starts.
    task automatic test_back_to_back();
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, '0);
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            bad++;
            $display("FAIL mult_const: got hi=%h lo=%h, expected hi=ffffffff lo=ffffffeb", hi, lo);
        end
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0);
`ifdef MULDIV_DIV_EN
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            bad++;
            $display("FAIL div_const: got hi=%h lo=%h, expected hi=ffffffff lo=fffffffd", hi, lo);
        end
`endif
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
`ifdef MULDIV_DIV_EN
        total++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000 || divzero !== 1'b0) begin
            bad++;
            $display("FAIL div_ovf: got hi=%h lo=%h dz=%b, expected hi=00000000 lo=80000000 dz=0", hi, lo, divzero);
        end
`endif
        do_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b0, '0);
`ifdef MULDIV_DIV_EN
        total++;
        if (hi !== 32'd100 || lo !== 32'hFFFF_FFFF || divzero !== 1'b1) begin
            bad++;
            $display("FAIL divzero: got hi=%h lo=%h dz=%b, expected hi=00000064 lo=ffffffff dz=1", hi, lo, divzero);
        end
`endif
        do_op(2'b00, 32'd3, 32'd4, 1'b0, 1'b0, '0);
        total++;
        if (divzero !== 1'b0 || lo !== 32'd12) begin
            bad++;
            $display("FAIL dz_clear: got dz=%b lo=%h, expected dz=0 lo=0000000c", divzero, lo);
        end
    endtask

    task automatic test_regwrite();
        tick();
        lo_we = 1'b1; wd = 32'h0000_1234;
        tick();
        lo_we = 1'b0;
        exp_lo = 32'h0000_1234;
        total++;
        if (lo !== 32'h0000_1234 || hi !== exp_hi) begin
            bad++;
            $display("FAIL lo_write: got hi=%h lo=%h, expected hi=%h lo=00001234", hi, lo, exp_hi);
        end
        hi_we = 1'b1; wd = $urandom;
        exp_hi = wd;
        tick();
        hi_we = 1'b0;
        total++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            bad++;
            $display("FAIL hi_write: got hi=%h lo=%h, expected hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
        end
        do_op(2'b01, $urandom, $urandom, 1'b1, 1'b1, 32'hCAFE_F00D);
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] x, y, rh, rl;
        logic         rz;
        tick();
        x = $urandom; y = $urandom;
        rh = exp_hi; rl = exp_lo; rz = exp_dz;
        model(2'b01, x, y, rh, rl, rz);
        start = 1'b1; op = 2'b01; a = x; b = y;
        tick();
        for (int c = 1; c <= W + 1; c++) begin
            start = (c == 5); op = 2'b00; a = $urandom; b = $urandom;
            lo_we = (c == 5); wd = 32'h0000_DEAD;
            tick();
        end
        start = 1'b0; lo_we = 1'b0;
        exp_hi = rh; exp_lo = rl; exp_dz = rz;
        total++;
        if ({done, hi, lo} !== {1'b1, rh, rl}) begin
            bad++;
            $display("FAIL busy_ignore: got done=%b hi=%h lo=%h, expected done=1 hi=%h lo=%h", done, hi, lo, rh, rl);
        end
        tick();
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL start_ignored: got busy=%b done=%b, expected busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        tick();
        start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        total++;
        if ({busy, done, hi, lo, divzero} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h dz=%b, expected all zero",
                     busy, done, hi, lo, divzero);
        end
        tick();
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            bad++;
            $display("FAIL aborted_done: got activity=%b hi=%h lo=%h, expected activity=0 hi=0 lo=0", seen, hi, lo);
        end
    endtask

    task automatic test_random();
        logic [1:0]   o;
        logic [W-1:0] x, y;
        int           sel;
        for (int n = 0; n < 50; n++) begin
            o = 2'($urandom); x = $urandom; y = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = '0;
            if (sel == 1) begin x = 32'h8000_0000; y = '1; end
            if (sel == 2) begin x = 32'($urandom_range(0, 20)); y = 32'($urandom_range(0, 5)); end
            do_op(o, x, y, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
            repeat ($urandom_range(0, 2)) begin
                tick();
                total++;
                if ({busy, done, hi, lo} !== {1'b0, 1'b0, exp_hi, exp_lo}) begin
                    bad++;
                    $display("FAIL idle_hold: got busy=%b done=%b hi=%h lo=%h, expected busy=0 done=0 hi=%h lo=%h",
                             busy, done, hi, lo, exp_hi, exp_lo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_latency();
        test_back_to_back();
        test_regwrite();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
